// File: rtl/dcache_port_arbiter.sv
// Arbitrates one wt_dcache load port between CPU loads (strict priority) and the stride prefetcher.
// Grant is combinational from IDLE, one transaction in flight; the losing side sees gnt=0 until IDLE.
package dcache_port_arbiter_pkg;
  localparam int unsigned DcacheIndexWidth = 12;
  localparam int unsigned DcacheTagWidth   = 20;
  localparam int unsigned XLen             = 32;

  typedef struct packed {
    logic [DcacheIndexWidth-1:0] address_index;
    logic [DcacheTagWidth-1:0]   address_tag;
    logic [XLen-1:0]             data_wdata;
    logic                        data_req;
    logic                        data_we;
    logic [XLen/8-1:0]           data_be;
    logic [1:0]                  data_size;
    logic                        kill_req;
    logic                        tag_valid;
  } dcache_req_i_t;

  typedef struct packed {
    logic            data_gnt;
    logic            data_rvalid;
    logic [XLen-1:0] data_rdata;
  } dcache_req_o_t;
endpackage

module dcache_port_arbiter
  import dcache_port_arbiter_pkg::*;
#(
  parameter int unsigned IdleThres = 16,
  parameter int unsigned CntWidth  = 8
) (
  input  logic          clk,
  input  logic          rst_i,
  input  logic          pf_en_i,
  input  dcache_req_i_t cpu_port_i,
  output dcache_req_o_t cpu_port_o,
  input  dcache_req_i_t pf_port_i,
  output dcache_req_o_t pf_port_o,
  output dcache_req_i_t cache_port_o,
  input  dcache_req_o_t cache_port_i,
  output logic          busy_o,
  output logic          owner_o,
  output logic [31:0]   pf_issued_o
);

  typedef enum logic [2:0] {IDLE, CPU_TAG, CPU_WAIT, PF_TAG, PF_WAIT} state_e;

  localparam logic [CntWidth-1:0] IdleMax = CntWidth'(IdleThres);

  state_e                      state_q, state_d;
  logic [CntWidth-1:0]         idle_cnt_q;
  logic                        owner_q;
  logic [31:0]                 pf_issued_q;
  logic [DcacheIndexWidth-1:0] index_q;

  logic                        pf_ok;
  logic                        pf_owns;
  logic                        cpu_grant;
  logic                        pf_grant;
  logic [DcacheTagWidth-1:0]   owner_tag;
  logic [1:0]                  owner_size;
  logic                        owner_tag_valid;
  logic                        owner_kill;
  dcache_req_o_t               owner_rsp;

  assign pf_ok   = pf_en_i && (idle_cnt_q == IdleMax);
  assign pf_owns = (state_q == PF_TAG) || (state_q == PF_WAIT);

  // Only the tag-phase fields of the owner are needed once the index phase is over.
  assign owner_tag       = pf_owns ? pf_port_i.address_tag : cpu_port_i.address_tag;
  assign owner_size      = pf_owns ? pf_port_i.data_size   : cpu_port_i.data_size;
  assign owner_tag_valid = pf_owns ? pf_port_i.tag_valid   : cpu_port_i.tag_valid;
  assign owner_kill      = pf_owns ? pf_port_i.kill_req    : cpu_port_i.kill_req;

  always_comb begin
    state_d      = state_q;
    cache_port_o = '0;
    cpu_port_o   = '0;
    pf_port_o    = '0;
    owner_rsp    = '0;
    cpu_grant    = 1'b0;
    pf_grant     = 1'b0;

    case (state_q)
      IDLE: begin
        if (cpu_port_i.data_req) begin
          cache_port_o           = cpu_port_i;
          cache_port_o.tag_valid = 1'b0;
          cache_port_o.kill_req  = 1'b0;
          cpu_port_o.data_gnt    = cache_port_i.data_gnt;
          cpu_grant              = cache_port_i.data_gnt;
        end else if (pf_port_i.data_req && pf_ok) begin
          cache_port_o           = pf_port_i;
          cache_port_o.tag_valid = 1'b0;
          cache_port_o.kill_req  = 1'b0;
          pf_port_o.data_gnt     = cache_port_i.data_gnt;
          pf_grant               = cache_port_i.data_gnt;
        end
        if (cpu_grant) begin
          state_d = CPU_TAG;
        end else if (pf_grant) begin
          state_d = PF_TAG;
        end
      end

      CPU_TAG, PF_TAG: begin
        cache_port_o.address_index = index_q;
        cache_port_o.address_tag   = owner_tag;
        cache_port_o.data_size     = owner_size;
        cache_port_o.tag_valid     = owner_tag_valid;
        cache_port_o.kill_req      = owner_kill;
        owner_rsp.data_rvalid      = cache_port_i.data_rvalid;
        owner_rsp.data_rdata       = cache_port_i.data_rdata;
        // A hit can return data in the same cycle the tag is presented.
        if (owner_kill || cache_port_i.data_rvalid) begin
          state_d = IDLE;
        end else if (owner_tag_valid) begin
          state_d = pf_owns ? PF_WAIT : CPU_WAIT;
        end
      end

      CPU_WAIT, PF_WAIT: begin
        owner_rsp.data_rvalid = cache_port_i.data_rvalid;
        owner_rsp.data_rdata  = cache_port_i.data_rdata;
        if (cache_port_i.data_rvalid) begin
          state_d = IDLE;
        end
      end

      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      if (pf_owns) begin
        pf_port_o = owner_rsp;
      end else begin
        cpu_port_o = owner_rsp;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      state_q     <= IDLE;
      idle_cnt_q  <= '0;
      owner_q     <= 1'b0;
      pf_issued_q <= '0;
      index_q     <= '0;
    end else begin
      state_q <= state_d;
      if (cpu_port_i.data_req) begin
        idle_cnt_q <= '0;
      end else if (idle_cnt_q < IdleMax) begin
        idle_cnt_q <= idle_cnt_q + CntWidth'(1);
      end
      if (cpu_grant) begin
        owner_q <= 1'b0;
        index_q <= cpu_port_i.address_index;
      end else if (pf_grant) begin
        owner_q     <= 1'b1;
        index_q     <= pf_port_i.address_index;
        pf_issued_q <= pf_issued_q + 32'd1;
      end
    end
  end

  assign busy_o      = (state_q != IDLE);
  assign owner_o     = owner_q;
  assign pf_issued_o = pf_issued_q;

endmodule
